// File: rtl/gpio_irq_dispatcher.sv
// gpio_irq_dispatcher
//   Host-side consumer of the GPIO controller interrupt interface. Picks one
//   pending, unmasked pin, offers its index to the host over valid/ready, waits
//   for the host's done pulse (or a timeout), then issues a one-cycle clear
//   pulse for that pin back to the controller.
//
// Optional build macro:
//   GPIO_IRQ_RR_EN  defined   -> round-robin selection starting after last_id
//                   undefined -> fixed priority, lowest pending index wins
//
// Ports:
//   clk          clock
//   rst_n        asynchronous active-low reset
//   int_status   [PIN_COUNT] pending flags from the controller
//   irq_mask     [PIN_COUNT] 1 = pin ignored for dispatch
//   int_clear    [PIN_COUNT] one-hot clear pulse to the controller
//   irq_valid    an interrupt index is offered
//   irq_id       [IDX_W] offered / in-service pin index
//   irq_ready    host accepts the offered index
//   irq_done     host finished servicing irq_id
//   busy         state machine not idle
//   timeout_err  sticky flag, set when a forced clear occurred
//   err_clear    clears timeout_err (a simultaneous set wins)

module gpio_irq_dispatcher #(
    parameter int unsigned PIN_COUNT   = 32,
    parameter int unsigned IDX_W       = 5,
    parameter int unsigned ACK_TIMEOUT = 255
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [PIN_COUNT-1:0] int_status,
    input  logic [PIN_COUNT-1:0] irq_mask,
    output logic [PIN_COUNT-1:0] int_clear,
    output logic                 irq_valid,
    output logic [IDX_W-1:0]     irq_id,
    input  logic                 irq_ready,
    input  logic                 irq_done,
    output logic                 busy,
    output logic                 timeout_err,
    input  logic                 err_clear
);

    localparam int unsigned TW      = (ACK_TIMEOUT < 1) ? 1 : $clog2(ACK_TIMEOUT + 1);
    localparam int unsigned TO_LAST = (ACK_TIMEOUT == 0) ? 0 : ACK_TIMEOUT - 1;

    typedef enum logic [2:0] {
        IDLE,
        OFFER,
        SERVICE,
        CLEAR,
        HOLD
    } state_t;

    state_t               state, state_d;
    logic [TW-1:0]        timer, timer_d;
    logic [IDX_W-1:0]     last_id, last_id_d;
    logic [IDX_W-1:0]     id_d, sel;
    logic                 valid_d, busy_d, err_d;
    logic [PIN_COUNT-1:0] clear_d;
    logic [PIN_COUNT-1:0] pending;
    logic                 timeout_hit;

    assign pending     = int_status & ~irq_mask;
    assign timeout_hit = (ACK_TIMEOUT != 0) && (timer == TW'(TO_LAST));

`ifdef GPIO_IRQ_RR_EN
    // Scan offsets from farthest to nearest so the nearest set bit after
    // last_id is the one left in sel; wrap is a subtract, not a modulo.
    always_comb begin : rr_select
        int unsigned start;
        int unsigned idx;
        sel   = '0;
        start = (int'(last_id) + 1 >= PIN_COUNT) ? 0 : int'(last_id) + 1;
        idx   = 0;
        for (int unsigned i = PIN_COUNT; i > 0; i--) begin
            idx = start + i - 1;
            if (idx >= PIN_COUNT) idx = idx - PIN_COUNT;
            if (pending[idx]) sel = IDX_W'(idx);
        end
    end
`else
    // Scan high to low so the lowest set index is the final assignment.
    always_comb begin : fixed_select
        sel = '0;
        for (int unsigned i = PIN_COUNT; i > 0; i--) begin
            if (pending[i-1]) sel = IDX_W'(i - 1);
        end
    end
`endif

    // Next-state and next-output logic; every output is registered below.
    always_comb begin
        state_d   = state;
        valid_d   = irq_valid;
        id_d      = irq_id;
        clear_d   = '0;
        timer_d   = timer;
        last_id_d = last_id;
        err_d     = timeout_err;

        // Evaluated before the state logic so a timeout set overrides it.
        if (err_clear) err_d = 1'b0;

        unique case (state)
            IDLE: begin
                if (|pending) begin
                    id_d    = sel;
                    valid_d = 1'b1;
                    state_d = OFFER;
                end
            end
            OFFER: begin
                if (irq_ready) begin
                    valid_d = 1'b0;
                    timer_d = '0;
                    state_d = SERVICE;
                end
            end
            SERVICE: begin
                if (timer != '1) timer_d = timer + 1'b1;
                // The clear register is loaded here so the pulse is visible
                // exactly while the machine sits in CLEAR.
                if (irq_done) begin
                    clear_d[irq_id] = 1'b1;
                    state_d         = CLEAR;
                end else if (timeout_hit) begin
                    clear_d[irq_id] = 1'b1;
                    err_d           = 1'b1;
                    state_d         = CLEAR;
                end
            end
            CLEAR: begin
                last_id_d = irq_id;
                state_d   = HOLD;
            end
            HOLD: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            irq_valid   <= 1'b0;
            irq_id      <= '0;
            int_clear   <= '0;
            timer       <= '0;
            last_id     <= IDX_W'(PIN_COUNT - 1);
            busy        <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            state       <= state_d;
            irq_valid   <= valid_d;
            irq_id      <= id_d;
            int_clear   <= clear_d;
            timer       <= timer_d;
            last_id     <= last_id_d;
            busy        <= busy_d;
            timeout_err <= err_d;
        end
    end

endmodule

// File: tb/tb_gpio_irq_dispatcher.sv
// Directed self-checking bench for gpio_irq_dispatcher (PIN_COUNT=32,
// ACK_TIMEOUT=8). Expected ids in the round-robin scenario depend on whether
// GPIO_IRQ_RR_EN is defined for the build.

module tb_gpio_irq_dispatcher;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] int_status;
    logic [31:0] irq_mask;
    logic [31:0] int_clear;
    logic        irq_valid;
    logic [4:0]  irq_id;
    logic        irq_ready;
    logic        irq_done;
    logic        busy;
    logic        timeout_err;
    logic        err_clear;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    gpio_irq_dispatcher #(
        .PIN_COUNT  (32),
        .IDX_W      (5),
        .ACK_TIMEOUT(8)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .int_status (int_status),
        .irq_mask   (irq_mask),
        .int_clear  (int_clear),
        .irq_valid  (irq_valid),
        .irq_id     (irq_id),
        .irq_ready  (irq_ready),
        .irq_done   (irq_done),
        .busy       (busy),
        .timeout_err(timeout_err),
        .err_clear  (err_clear)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_reset();
        int_status = '0; irq_mask = '0; irq_ready = 0; irq_done = 0; err_clear = 0;
        rst_n = 1'b0;
        tick();
        tick();
        total++;
        if ({irq_valid, irq_id, busy, timeout_err} !== 8'h00 || int_clear !== 32'h0) begin
            bad++;
            $display("FAIL reset_outputs got valid=%b id=%0d busy=%b err=%b clr=%h want all 0",
                     irq_valid, irq_id, busy, timeout_err, int_clear);
        end
        rst_n = 1'b1;
        tick();
        tick();
        total++;
        if (busy !== 1'b0 || irq_valid !== 1'b0) begin
            bad++;
            $display("FAIL reset_idle got busy=%b valid=%b want 0 0", busy, irq_valid);
        end
    endtask

    task automatic test_basic();
        int_status = 32'h0000_0010;
        tick();
        total++;
        if (irq_valid !== 1'b1 || irq_id !== 5'd4 || busy !== 1'b1) begin
            bad++;
            $display("FAIL basic_offer got valid=%b id=%0d busy=%b want 1 4 1", irq_valid, irq_id, busy);
        end
        irq_ready = 1;
        tick();
        irq_ready = 0;
        total++;
        if (irq_valid !== 1'b0 || busy !== 1'b1) begin
            bad++;
            $display("FAIL basic_accept got valid=%b busy=%b want 0 1", irq_valid, busy);
        end
        tick();
        tick();
        irq_done = 1;
        tick();
        irq_done = 0;
        int_status = '0;
        total++;
        if (int_clear !== 32'h0000_0010) begin
            bad++;
            $display("FAIL basic_clear got %h want 00000010", int_clear);
        end
        tick();
        total++;
        if (int_clear !== 32'h0 || busy !== 1'b1) begin
            bad++;
            $display("FAIL basic_hold got clr=%h busy=%b want 0 1", int_clear, busy);
        end
        tick();
        total++;
        if (busy !== 1'b0 || irq_valid !== 1'b0 || timeout_err !== 1'b0) begin
            bad++;
            $display("FAIL basic_idle got busy=%b valid=%b err=%b want 0 0 0", busy, irq_valid, timeout_err);
        end
    endtask

    task automatic test_mask_hold();
        int_status = 32'h0000_0005;
        irq_mask   = 32'h0000_0001;
        tick();
        total++;
        if (irq_valid !== 1'b1 || irq_id !== 5'd2) begin
            bad++;
            $display("FAIL mask_offer got valid=%b id=%0d want 1 2", irq_valid, irq_id);
        end
        // Source drops and mask changes while the host stalls.
        int_status = '0;
        irq_mask   = 32'hFFFF_FFFF;
        for (int i = 0; i < 10; i++) begin
            tick();
            total++;
            if (irq_valid !== 1'b1 || irq_id !== 5'd2) begin
                bad++;
                $display("FAIL hold_valid cyc=%0d got valid=%b id=%0d want 1 2", i, irq_valid, irq_id);
            end
        end
        // done alongside ready in OFFER must not count.
        irq_ready = 1;
        irq_done  = 1;
        tick();
        irq_ready = 0;
        irq_done  = 0;
        tick();
        tick();
        total++;
        if (int_clear !== 32'h0 || busy !== 1'b1) begin
            bad++;
            $display("FAIL done_in_offer got clr=%h busy=%b want 0 1", int_clear, busy);
        end
        irq_done = 1;
        tick();
        irq_done = 0;
        total++;
        if (int_clear !== 32'h0000_0004) begin
            bad++;
            $display("FAIL mask_clear got %h want 00000004", int_clear);
        end
        irq_mask = '0;
        tick();
        tick();
    endtask

    task automatic test_timeout();
        int_status = 32'h0000_0002;
        tick();
        irq_ready = 1;
        tick();
        irq_ready = 0;
        for (int i = 1; i <= 7; i++) begin
            tick();
            total++;
            if (int_clear !== 32'h0) begin
                bad++;
                $display("FAIL timeout_early cyc=%0d got %h want 0", i, int_clear);
            end
        end
        tick();
        int_status = '0;
        total++;
        if (int_clear !== 32'h0000_0002 || timeout_err !== 1'b1) begin
            bad++;
            $display("FAIL timeout_fire got clr=%h err=%b want 00000002 1", int_clear, timeout_err);
        end
        tick();
        tick();
        total++;
        if (timeout_err !== 1'b1 || busy !== 1'b0) begin
            bad++;
            $display("FAIL timeout_sticky got err=%b busy=%b want 1 0", timeout_err, busy);
        end
        err_clear = 1;
        tick();
        err_clear = 0;
        total++;
        if (timeout_err !== 1'b0) begin
            bad++;
            $display("FAIL err_clear got %b want 0", timeout_err);
        end
        // err_clear held through a second timeout: the set must win.
        int_status = 32'h0000_0002;
        err_clear  = 1;
        tick();
        irq_ready = 1;
        tick();
        irq_ready = 0;
        for (int i = 0; i < 8; i++) tick();
        int_status = '0;
        total++;
        if (timeout_err !== 1'b1) begin
            bad++;
            $display("FAIL err_set_priority got %b want 1", timeout_err);
        end
        tick();
        err_clear = 0;
        total++;
        if (timeout_err !== 1'b0) begin
            bad++;
            $display("FAIL err_clear_after got %b want 0", timeout_err);
        end
        tick();
    endtask

    task automatic test_done_vs_timeout();
        int_status = 32'h0000_0002;
        tick();
        irq_ready = 1;
        tick();
        irq_ready = 0;
        for (int i = 0; i < 7; i++) tick();
        irq_done = 1;
        tick();
        irq_done = 0;
        int_status = '0;
        total++;
        if (int_clear !== 32'h0000_0002 || timeout_err !== 1'b0) begin
            bad++;
            $display("FAIL done_wins got clr=%h err=%b want 00000002 0", int_clear, timeout_err);
        end
        tick();
        tick();
    endtask

    task automatic test_round_robin();
        logic [4:0]  exp_id;
        logic [31:0] exp_clr;
        do_reset();
        int_status = 32'h0000_0009;
        for (int k = 0; k < 4; k++) begin
`ifdef GPIO_IRQ_RR_EN
            exp_id = (k % 2 == 0) ? 5'd0 : 5'd3;
`else
            exp_id = 5'd0;
`endif
            exp_clr = 32'h1 << exp_id;
            tick();
            total++;
            if (irq_valid !== 1'b1 || irq_id !== exp_id) begin
                bad++;
                $display("FAIL rr_offer k=%0d got valid=%b id=%0d want 1 %0d", k, irq_valid, irq_id, exp_id);
            end
            irq_ready = 1;
            tick();
            irq_ready = 0;
            irq_done  = 1;
            tick();
            irq_done  = 0;
            total++;
            if (int_clear !== exp_clr) begin
                bad++;
                $display("FAIL rr_clear k=%0d got %h want %h", k, int_clear, exp_clr);
            end
            tick();
            tick();
        end
        tick();
        int_status = '0;
        tick();
        tick();
    endtask

    task automatic test_reset_midop();
        int_status = 32'h0000_0040;
        tick();
        irq_ready = 1;
        tick();
        irq_ready = 0;
        tick();
        irq_done = 1;
        rst_n    = 1'b0;
        #1;
        total++;
        if ({irq_valid, irq_id, busy, timeout_err} !== 8'h00 || int_clear !== 32'h0) begin
            bad++;
            $display("FAIL midop_async got valid=%b id=%0d busy=%b err=%b clr=%h want all 0",
                     irq_valid, irq_id, busy, timeout_err, int_clear);
        end
        for (int i = 0; i < 3; i++) begin
            tick();
            total++;
            if (int_clear !== 32'h0) begin
                bad++;
                $display("FAIL midop_noclear cyc=%0d got %h want 0", i, int_clear);
            end
        end
        irq_done = 0;
        rst_n    = 1'b1;
        tick();
        total++;
        if (irq_valid !== 1'b1 || irq_id !== 5'd6) begin
            bad++;
            $display("FAIL midop_reoffer got valid=%b id=%0d want 1 6", irq_valid, irq_id);
        end
        irq_ready = 1;
        tick();
        irq_ready = 0;
        irq_done  = 1;
        tick();
        irq_done  = 0;
        int_status = '0;
        tick();
        tick();
    endtask

    initial begin
        test_reset();
        test_basic();
        test_mask_hold();
        test_timeout();
        test_done_vs_timeout();
        test_round_robin();
        test_reset_midop();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/gpio_irq_dispatcher.md
Name: gpio_irq_dispatcher

Overview:
- Host-side consumer of the GPIO controller's interrupt interface.
- Watches the per-pin interrupt status vector and selects one pending, unmasked pin.
- Hands that pin's index to the host over a valid/ready handshake, then waits for a service-done pulse.
- Issues the one-cycle per-pin clear pulse back to the controller; timeout recovery covers a host that never completes.

Parameters:
- PIN_COUNT, 32, number of interrupt sources; range 2..256.
- IDX_W, 5, width of irq_id; must equal ceil(log2(PIN_COUNT)).
- ACK_TIMEOUT, 255, max cycles in SERVICE before a forced clear; 0 disables the timeout.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset, asynchronous, active-low.
- int_status  in  PIN_COUNT  pending flags from the GPIO controller (registered there).
- irq_mask  in  PIN_COUNT  1 = pin ignored for dispatch.
- int_clear  out  PIN_COUNT  one-hot clear pulse to the controller.
- irq_valid  out  1  an interrupt index is offered.
- irq_id  out  IDX_W  offered / in-service pin index.
- irq_ready  in  1  host accepts the offered index.
- irq_done  in  1  host has finished servicing irq_id.
- busy  out  1  FSM not in IDLE.
- timeout_err  out  1  sticky: a forced clear occurred.
- err_clear  in  1  clears timeout_err.

Behaviour:
- Reset values: int_clear=0, irq_valid=0, irq_id=0, busy=0, timeout_err=0, FSM=IDLE, timer=0, last_id=PIN_COUNT-1.
- All outputs are registered.
- pending = int_status & ~irq_mask.
- IDLE: if pending != 0, latch selected index into irq_id, set irq_valid, go OFFER. A pending bit seen at edge N gives irq_valid=1 after edge N+1 (1-cycle latency).
- Selection (default): lowest set index of pending.
- OFFER:
  - irq_valid and irq_id hold stable until irq_ready=1 (no retraction, even if the status bit drops or the mask changes).
  - On irq_ready: irq_valid=0, timer=0, go SERVICE.
- SERVICE:
  - timer increments each cycle, saturating.
  - On irq_done: go CLEAR.
  - Else, if ACK_TIMEOUT != 0 and timer == ACK_TIMEOUT-1: set timeout_err, go CLEAR.
  - If irq_done and timeout occur in the same cycle, done wins and timeout_err is not set.
- CLEAR: int_clear[irq_id]=1 for exactly one cycle, update last_id=irq_id, go HOLD.
- HOLD: one cycle with int_clear=0, giving the controller time to drop the status bit; then go IDLE. A level-type source still active is legitimately re-offered.
- irq_ready is ignored outside OFFER; irq_done is ignored outside SERVICE, including when asserted together with irq_ready in OFFER.
- timeout_err: set has priority over err_clear in the same cycle.
- busy = (state != IDLE).
- Reset mid-operation: immediate return to reset values and no clear is issued. A controller bit that is still set is re-offered after reset.
- Width rules: the timer width covers ACK_TIMEOUT; indices ≥ PIN_COUNT are never produced.

Optional Feature:
- Macro GPIO_IRQ_RR_EN.
- Defined: round-robin selection. The search starts at last_id+1, wraps modulo PIN_COUNT, and picks the first set pending bit. Because last_id resets to PIN_COUNT-1, the first search starts at 0.
- Undefined: fixed priority, lowest index wins; last_id is still tracked but unused for selection.

Test Plan:
- int_status=0x0000_0010, mask=0 → irq_valid=1, irq_id=4 one cycle later. Then ready, then done 3 cycles later → int_clear=0x10 for one cycle, HOLD, IDLE, busy=0.
- int_status=0x0000_0005, mask=0x1, fixed priority → irq_id=2 offered; pin 0 never offered while masked.
- Hold valid: irq_ready low for 10 cycles while int_status drops to 0 → irq_valid stays 1 with irq_id constant until ready.
- ACK_TIMEOUT=8, ready and never done → int_clear pulse exactly 8 cycles after acceptance and timeout_err=1. err_clear → timeout_err=0. Done and timeout in the same cycle → timeout_err stays 0.
- GPIO_IRQ_RR_EN defined, int_status held at 0x0000_0009 (level-type, re-asserting) → offered ids 0, 3, 0, 3…. Without the macro → 0, 0, 0….
- rst_n asserted in SERVICE → all outputs 0 asynchronously, no int_clear. After release, the still-pending pin is re-offered.
